// File: rtl/booth4_pkg.sv
// Shared types for the radix-4 Booth multiplier with round-robin front end.
package booth4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Booth digit triplets {b[2i+1], b[2i], b[2i-1]}
   localparam logic [2:0] DIG_Z0  = 3'b000;
   localparam logic [2:0] DIG_P1A = 3'b001;
   localparam logic [2:0] DIG_P1B = 3'b010;
   localparam logic [2:0] DIG_P2  = 3'b011;
   localparam logic [2:0] DIG_M2  = 3'b100;
   localparam logic [2:0] DIG_M1A = 3'b101;
   localparam logic [2:0] DIG_M1B = 3'b110;
   localparam logic [2:0] DIG_Z1  = 3'b111;

endpackage

// File: rtl/booth4_step.sv
// One radix-4 Booth iteration: add the decoded partial product to the upper
// accumulator field, then shift the whole accumulator right by two.
module booth4_step
   import booth4_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [2:0]     i_digit,
   input  logic [N-1:0]   i_mcand,
   input  logic [2*N+1:0] i_acc,
   output logic [2*N+1:0] o_acc_next
);

   logic [N+1:0]   w_m;
   logic [N+1:0]   w_pp;
   logic [N+1:0]   w_sum;
   logic [2*N+1:0] w_cat;

   assign w_m = {{2{i_mcand[N-1]}}, i_mcand};

   always_comb begin
      w_pp = '0;
      case (i_digit)
         DIG_P1A, DIG_P1B: w_pp = w_m;
         DIG_P2:           w_pp = w_m << 1;
         DIG_M2:           w_pp = '0 - (w_m << 1);
         DIG_M1A, DIG_M1B: w_pp = '0 - w_m;
         default:          w_pp = '0;
      endcase
   end

   // N+2 bits hold the running upper sum without overflow, even for 2*(-2^(N-1))
   assign w_sum      = i_acc[2*N+1:N] + w_pp;
   assign w_cat      = {w_sum, i_acc[N-1:0]};
   assign o_acc_next = {{2{w_sum[N+1]}}, w_cat[2*N+1:2]};

endmodule

// File: rtl/booth4_mult_arbiter.sv
// Round-robin arbitrated, sequential radix-4 Booth signed multiplier:
// one digit per CALC cycle, fixed latency, response held until accepted.
module booth4_mult_arbiter
   import booth4_pkg::*;
#(
   parameter int N    = 32,
   parameter int REQS = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [REQS-1:0]                         req_valid,
   output logic [REQS-1:0]                         req_ready,
   input  logic [REQS*N-1:0]                       req_multiplicand,
   input  logic [REQS*N-1:0]                       req_multiplier,
   output logic                                    rsp_valid,
   input  logic                                    rsp_ready,
   output logic [2*N-1:0]                          rsp_product,
   output logic [((REQS > 1) ? $clog2(REQS) : 1)-1:0] rsp_id,
   output logic                                    busy
);

   localparam int IDW = (REQS > 1) ? $clog2(REQS) : 1;
   localparam int CW  = $clog2(N/2) + 1;
   localparam int AW  = 2*N + 2;

   state_t           r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_id;
   logic [N-1:0]     r_mcand;
   logic [N:0]       r_mplr;
   logic [AW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic [2*N-1:0]   r_product;
   logic             r_rsp_valid;
   logic             r_busy;

   logic [REQS-1:0]  w_grant;
   logic [IDW-1:0]   w_grant_id;
   logic [IDW-1:0]   w_next_ptr;
   logic             w_any;
   logic [AW-1:0]    w_acc_next;

   always_comb begin
      int unsigned v_idx;
      logic [IDW-1:0] v_id;
      w_any      = 1'b0;
      w_grant_id = '0;
      v_idx      = 0;
      v_id       = '0;
      for (int unsigned k = 0; k < REQS; k++) begin
         v_idx = (int'(r_rr_ptr) + k) % REQS;
         v_id  = IDW'(v_idx);
         if (!w_any && req_valid[v_id]) begin
            w_any      = 1'b1;
            w_grant_id = v_id;
         end
      end
      w_grant = w_any ? (REQS'(1) << w_grant_id) : '0;
   end

   assign w_next_ptr  = (w_grant_id == IDW'(REQS-1)) ? '0 : w_grant_id + 1'b1;
   assign req_ready   = (r_state == IDLE && rst_n) ? w_grant : '0;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_product = r_product;
   assign rsp_id      = r_id;
   assign busy        = r_busy;

   booth4_step #(.N(N)) u_step (
      .i_digit    (r_mplr[2:0]),
      .i_mcand    (r_mcand),
      .i_acc      (r_acc),
      .o_acc_next (w_acc_next)
   );

   // CALC spends N/2 cycles stepping plus one cycle latching the product
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_id        <= '0;
         r_mcand     <= '0;
         r_mplr      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_product   <= '0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_mcand  <= req_multiplicand[int'(w_grant_id)*N +: N];
                  r_mplr   <= {req_multiplier[int'(w_grant_id)*N +: N], 1'b0};
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_id     <= w_grant_id;
                  r_rr_ptr <= w_next_ptr;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               if (r_cnt == CW'(N/2)) begin
                  r_product   <= r_acc[2*N-1:0];
                  r_rsp_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_acc  <= w_acc_next;
                  r_mplr <= r_mplr >> 2;
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/booth4_mult_arbiter.md
BOOTH4_MULT_ARBITER -- requirements
Module: booth4_mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 32: operand width, signed two's complement; N even and >= 4.
REQ-002 SHALL have parameter REQS, default 2: number of requesters, 2..8.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, REQS: per-requester operand-valid.
REQ-006 SHALL have port req_ready, output, REQS: per-requester accept, at most one bit high.
REQ-007 SHALL have port req_multiplicand, input, REQS*N: packed, requester k at bits [k*N +: N].
REQ-008 SHALL have port req_multiplier, input, REQS*N: packed, same layout.
REQ-009 SHALL have port rsp_valid, output, 1: product valid.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts product.
REQ-011 SHALL have port rsp_product, output, 2*N: signed product.
REQ-012 SHALL have port rsp_id, output, clog2(REQS) (min 1): index of the requester that owns rsp_product.
REQ-013 SHALL have port busy, output, 1: high in CALC and DONE.

Function
REQ-014 SHALL use a three-state FSM: IDLE -> CALC on accept; CALC -> DONE after N/2 iterations; DONE -> IDLE when rsp_valid and rsp_ready are both high.
REQ-015 In IDLE, req_ready SHALL be one-hot to the round-robin winner among asserted req_valid bits (combinational), and SHALL be zero in CALC and DONE.
REQ-016 Round-robin SHALL search from pointer rr_ptr upward, wrapping; after accepting requester g, rr_ptr SHALL become (g+1) mod REQS.
REQ-017 On accept, the block SHALL register both operands and the winner id; later changes on the request inputs SHALL not affect the result.
REQ-018 Each CALC cycle SHALL retire one radix-4 Booth digit from multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0, for i = 0..N/2-1.
REQ-019 Digit decode SHALL be: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
REQ-020 The partial product SHALL be sign-extended to N+2 bits, added to the upper accumulator, and the accumulator SHALL then be arithmetic-shifted right by 2.
REQ-021 rsp_product SHALL equal the exact signed product for all operands, including -2^(N-1) x -2^(N-1) = 2^(2N-2). No post-correction and no zero-operand shortcut.
REQ-022 Latency SHALL be fixed: with accept at edge E, rsp_valid SHALL go high after edge E+N/2+1 (17 cycles at N=32).
REQ-023 rsp_valid, rsp_product and rsp_id SHALL hold stable in DONE until rsp_ready is sampled high.
REQ-024 A request that is valid while the block is busy SHALL wait and SHALL be considered at the first IDLE cycle; a new accept SHALL not occur in the same cycle the response handshake completes.

Reset
REQ-025 With rst_n low at a clock edge, the FSM SHALL go to IDLE, rr_ptr to 0, and rsp_valid, busy, req_ready, rsp_product and rsp_id to 0.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation with no response; the aborted request is lost and the requester must re-issue it.

Structure
REQ-027 Package booth4_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the Booth digit encoding constants.
REQ-028 Sub-module booth4_step (combinational: digit, multiplicand, accumulator in; next accumulator out) SHALL implement REQ-019 and REQ-020, with one instance.
REQ-029 Iteration counter width SHALL be clog2(N/2)+1.

Verification
REQ-030 Request 0: 7 x -3 -> rsp_product = -21, rsp_id = 0, rsp_valid 17 cycles after accept (N=32).
REQ-031 Corner operands: 0x80000000 x 0x80000000 -> 0x4000000000000000; 0x80000000 x 1 -> 0xFFFFFFFF80000000; 0x7FFFFFFF x 0x7FFFFFFF -> 0x3FFFFFFF00000001.
REQ-032 Both requesters held valid for 4 operations -> grants alternate 0,1,0,1; each rsp_id matches its operands.
REQ-033 rsp_ready held low 5 cycles in DONE -> product and id stable, req_ready stays 0, then exactly one handshake.
REQ-034 rst_n low in iteration 8 of CALC -> next cycle IDLE, rsp_valid 0; a re-issued request gives the correct product.
REQ-035 10,000 random signed operand pairs with random valid/ready stalls -> every product matches the reference model and no response is lost or duplicated.
